dino_axil_cmd_arbiter: RTL and testbench
========================================

# dino_axil_cmd_arbiter

Two-requester command arbiter and AXI4-Lite master sequencer for the dino controller's register slave (four 32-bit registers at offsets 0x0, 0x4, 0x8, 0xC). Requester 0 is the game-state engine and requester 1 is the debug/host path. Each requester posts a simple single-word read or write command. The block grants requesters round-robin, runs exactly one AXI4-Lite transaction at a time, and returns the read data and response to the granted requester.

## Interface
- ADDR_W, 4, AXI address width in bits (byte address).
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- req_i[1:0]  in  2  command request per requester; held high until that requester's done.
- we_i[1:0]  in  2  1 = write, 0 = read; per requester.
- addr0_i, addr1_i  in  ADDR_W  byte address per requester.
- wdata0_i, wdata1_i  in  32  write data per requester.
- done_o[1:0]  out  2  one-cycle completion pulse to the served requester.
- rdata_o  out  32  read data; valid while done_o is nonzero.
- resp_o  out  2  BRESP or RRESP of the completed transaction; valid while done_o is nonzero.
- busy_o  out  1  high from grant until the done pulse, inclusive.
- m_awaddr, m_awvalid, m_awready  out/out/in  ADDR_W/1/1  AXI4-Lite write address channel.
- m_wdata, m_wstrb, m_wvalid, m_wready  out/out/out/in  32/4/1/1  write data channel; m_wstrb is constant 4'hF.
- m_bresp, m_bvalid, m_bready  in/in/out  2/1/1  write response channel.
- m_araddr, m_arvalid, m_arready  out/out/in  ADDR_W/1/1  read address channel.
- m_rdata, m_rresp, m_rvalid, m_rready  in/in/in/out  32/2/1/1  read data channel.
- m_awprot and m_arprot are tied to 3'b000 outside the block; no prot ports here.

## Operation
- FSM states:
  - IDLE.
  - WADDR: AW and W are both pending.
  - WRESP.
  - RADDR.
  - RRESP.
  - DONE.
- IDLE with any req_i bit set:
  - Arbitrate and latch the winner index, we, addr and wdata.
  - Go to WADDR if we = 1, otherwise RADDR.
- Arbitration is round-robin with a last-served pointer, reset value 1 (so requester 0 wins first).
  - Single request: that requester wins.
  - Both requesting: the requester not last served wins.
  - The pointer updates on grant.
- Address bits [1:0] are driven as 0 on m_awaddr and m_araddr. Misaligned requests are silently word-aligned.
- WADDR:
  - m_awvalid and m_wvalid are asserted together.
  - Each one drops independently on the cycle after its own valid&ready handshake.
  - Move to WRESP once both handshakes are done; they may occur in the same or different cycles, in either order.
- WRESP: m_bready = 1. On m_bvalid, capture m_bresp and go to DONE.
- RADDR: m_arvalid = 1. On m_arready, go to RRESP.
- RRESP: m_rready = 1. On m_rvalid, capture m_rdata and m_rresp and go to DONE.
- DONE:
  - done_o[winner] = 1 for one cycle.
  - rdata_o = captured read data (0 for writes); resp_o = captured response.
  - Return to IDLE.
- Requester obligations:
  - Hold req_i and the command fields stable until done_o.
  - Dropping req_i mid-transaction does not abort; the transaction completes and done_o still pulses.
- Non-OKAY responses (SLVERR, DECERR) are passed through on resp_o with no retry.

## Timing
- Reset values: all valid/ready outputs 0, done_o 0, busy_o 0, rdata_o 0, resp_o 0, m_awaddr/m_araddr/m_wdata 0, FSM in IDLE, pointer 1.
- ARESET asserted mid-transaction clears all outputs immediately (asynchronous). The slave may see a truncated handshake; this is accepted.
- Request sampled in cycle N (IDLE) → the AXI valid is registered high in cycle N+1.
- Best-case latency with a zero-wait slave (ready already high, response in the next cycle):
  - Write: req to done = 4 cycles (grant, AW/W handshake, B, DONE).
  - Read: req to done = 4 cycles (grant, AR, R, DONE).
- No new grant is issued in DONE. The earliest next grant is the IDLE cycle after DONE, so back-to-back commands are spaced at 5 cycles minimum.
- All AXI valids stay stable until their handshake completes (AXI rule); address and data do not change while valid is high.
- m_bready and m_rready are high only in WRESP and RRESP respectively.

## Test plan
- Single writes from requester 0: 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then reads back → rdata_o = 0x1..0x4, resp_o = 0, exactly one done_o[0] pulse per command.
- Both requesting in the same cycle straight after reset: r0 writes 0xA5 to 0x0, r1 writes 0x5A to 0x4 → r0 is served first, then r1. Repeating with both held gives alternating grants r0, r1, r0, r1.
- Slave holds m_wready low 3 cycles after m_awready → m_awvalid drops after its handshake, m_wvalid stays high with stable data, and m_bready rises only after the W handshake.
- Slave returns m_rresp = 2'b10 on a read of 0x8 → resp_o = 2'b10 and rdata_o = captured m_rdata on the done pulse; no retry.
- ARESET asserted while in RRESP → all AXI valid/ready and busy_o go to 0 in the same cycle with no done_o. After release, r0 wins first.
- Misaligned r1 read of addr 0x7 → m_araddr = 0x4.

Source files
------------

// File: rtl/dino_axil_cmd_arbiter_if.sv
// rtl/dino_axil_cmd_arbiter_if.sv - AXI4-Lite master bus bundle used by the dino command arbiter
`timescale 1ns/1ps

interface dino_axil_cmd_arbiter_if #(
  parameter int ADDR_W = 4
);

  // Write address channel
  logic [ADDR_W-1:0] m_awaddr;
  logic              m_awvalid;
  logic              m_awready;

  // Write data channel
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_wvalid;
  logic              m_wready;

  // Write response channel
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;

  // Read address channel
  logic [ADDR_W-1:0] m_araddr;
  logic              m_arvalid;
  logic              m_arready;

  // Read data channel
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;

  // Sequencer side: drives addresses, data, valids and response readies
  modport master (
    output m_awaddr, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready,
    output m_araddr, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rvalid,
    output m_rready
  );

  // Register slave side
  modport slave (
    input  m_awaddr, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready,
    input  m_araddr, m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rvalid,
    input  m_rready
  );

endinterface

// File: rtl/dino_axil_cmd_arbiter.sv
// rtl/dino_axil_cmd_arbiter.sv - two-requester round-robin arbiter sequencing single AXI4-Lite transactions
`timescale 1ns/1ps

module dino_axil_cmd_arbiter #(
  parameter int ADDR_W = 4
) (
  input  logic               ACLK,
  input  logic               ARESET,

  // Requester command ports (requester 0 = game-state engine, 1 = debug/host)
  input  logic [1:0]         req_i,
  input  logic [1:0]         we_i,
  input  logic [ADDR_W-1:0]  addr0_i,
  input  logic [ADDR_W-1:0]  addr1_i,
  input  logic [31:0]        wdata0_i,
  input  logic [31:0]        wdata1_i,

  // Completion back to the served requester
  output logic [1:0]         done_o,
  output logic [31:0]        rdata_o,
  output logic [1:0]         resp_o,
  output logic               busy_o,

  // AXI4-Lite master towards the register slave
  dino_axil_cmd_arbiter_if.master m_axi
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RRESP = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Word-alignment mask: the slave only decodes whole 32-bit registers
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(2'b11));

  state_t            r_state;
  logic              r_ptr;       // index of the requester served last
  logic              r_win;       // index of the requester being served now

  logic [ADDR_W-1:0] r_awaddr;
  logic              r_awvalid;
  logic [31:0]       r_wdata;
  logic              r_wvalid;
  logic              r_bready;
  logic [ADDR_W-1:0] r_araddr;
  logic              r_arvalid;
  logic              r_rready;

  logic [1:0]        r_done;
  logic [31:0]       r_rdata;
  logic [1:0]        r_resp;
  logic              r_busy;

  logic              w_win;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [ADDR_W-1:0] w_aligned;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_aw_clear;
  logic              w_w_clear;
  logic [1:0]        w_win_onehot;

  // Round-robin pick plus the winner's command fields
  always_comb begin
    w_win       = 1'b0;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (req_i == 2'b11) begin
      // Both pending: the one not served last goes next
      w_win = ~r_ptr;
    end else begin
      w_win = req_i[1];
    end
    if (w_win) begin
      w_sel_we    = we_i[1];
      w_sel_addr  = addr1_i;
      w_sel_wdata = wdata1_i;
    end else begin
      w_sel_we    = we_i[0];
      w_sel_addr  = addr0_i;
      w_sel_wdata = wdata0_i;
    end
    w_aligned = w_sel_addr & WORD_MASK;
  end

  // Handshake decode for the write-address/data phase; AW and W retire independently
  always_comb begin
    w_aw_hs      = r_awvalid & m_axi.m_awready;
    w_w_hs       = r_wvalid & m_axi.m_wready;
    w_aw_clear   = ~r_awvalid | w_aw_hs;
    w_w_clear    = ~r_wvalid | w_w_hs;
    w_win_onehot = r_win ? 2'b10 : 2'b01;
  end

  // Sequencer FSM: grant, run one AXI transaction, pulse done to the winner
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= S_IDLE;
      r_ptr     <= 1'b1;
      r_win     <= 1'b0;
      r_awaddr  <= '0;
      r_awvalid <= 1'b0;
      r_wdata   <= '0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_done    <= 2'b00;
      r_rdata   <= '0;
      r_resp    <= 2'b00;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req_i) begin
            r_win  <= w_win;
            r_ptr  <= w_win;
            r_busy <= 1'b1;
            if (w_sel_we) begin
              r_awaddr  <= w_aligned;
              r_wdata   <= w_sel_wdata;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WADDR;
            end else begin
              r_araddr  <= w_aligned;
              r_arvalid <= 1'b1;
              r_state   <= S_RADDR;
            end
          end
        end

        S_WADDR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
          end
          // Both channels retired (now or earlier): wait for the response
          if (w_aw_clear && w_w_clear) begin
            r_bready <= 1'b1;
            r_state  <= S_WRESP;
          end
        end

        S_WRESP: begin
          if (m_axi.m_bvalid) begin
            r_bready <= 1'b0;
            r_resp   <= m_axi.m_bresp;
            r_rdata  <= '0;
            r_done   <= w_win_onehot;
            r_state  <= S_DONE;
          end
        end

        S_RADDR: begin
          if (m_axi.m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RRESP;
          end
        end

        S_RRESP: begin
          if (m_axi.m_rvalid) begin
            r_rready <= 1'b0;
            r_rdata  <= m_axi.m_rdata;
            r_resp   <= m_axi.m_rresp;
            r_done   <= w_win_onehot;
            r_state  <= S_DONE;
          end
        end

        S_DONE: begin
          // No grant here; the next one can only happen from IDLE
          r_done  <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_axi.m_awaddr  = r_awaddr;
  assign m_axi.m_awvalid = r_awvalid;
  assign m_axi.m_wdata   = r_wdata;
  assign m_axi.m_wstrb   = 4'hF;
  assign m_axi.m_wvalid  = r_wvalid;
  assign m_axi.m_bready  = r_bready;
  assign m_axi.m_araddr  = r_araddr;
  assign m_axi.m_arvalid = r_arvalid;
  assign m_axi.m_rready  = r_rready;

  assign done_o  = r_done;
  assign rdata_o = r_rdata;
  assign resp_o  = r_resp;
  assign busy_o  = r_busy;

endmodule

// File: tb/tb_dino_axil_cmd_arbiter.sv
// tb/tb_dino_axil_cmd_arbiter.sv - directed self-checking bench for dino_axil_cmd_arbiter
`timescale 1ns/1ps

module tb_dino_axil_cmd_arbiter;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic [1:0]        done;
  logic [31:0]       rdata;
  logic [1:0]        resp;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dino_axil_cmd_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dino_axil_cmd_arbiter #(.ADDR_W(ADDR_W)) dut (
    .ACLK     (clk),
    .ARESET   (rst),
    .req_i    (req),
    .we_i     (we),
    .addr0_i  (addr0),
    .addr1_i  (addr1),
    .wdata0_i (wdata0),
    .wdata1_i (wdata1),
    .done_o   (done),
    .rdata_o  (rdata),
    .resp_o   (resp),
    .busy_o   (busy),
    .m_axi    (bus)
  );

  // Slave behaviour knobs, written by the test tasks only
  int          w_stall_cfg;
  int          r_delay_cfg;
  logic [1:0]  bresp_cfg;
  logic [1:0]  rresp_cfg;

  // Slave model state, written by the slave process only
  logic [31:0] mem [4];
  logic        c_aw, c_w, c_b, c_ar, c_r;
  logic [3:0]  c_awaddr, c_araddr;
  logic [31:0] c_wdata;
  logic        aw_got, w_got, ar_got, aw_prev;
  logic [3:0]  aw_a, ar_a;
  logic [31:0] w_d;
  int          w_stall_left, r_delay_left;

  // Four-register AXI4-Lite slave: samples handshakes at posedge, drives at negedge
  always begin
    @(posedge clk);
    c_aw     = bus.m_awvalid & bus.m_awready;
    c_awaddr = bus.m_awaddr;
    c_w      = bus.m_wvalid & bus.m_wready;
    c_wdata  = bus.m_wdata;
    c_b      = bus.m_bvalid & bus.m_bready;
    c_ar     = bus.m_arvalid & bus.m_arready;
    c_araddr = bus.m_araddr;
    c_r      = bus.m_rvalid & bus.m_rready;
    @(negedge clk);
    if (rst) begin
      bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_arready = 1'b0;
      bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00;
      bus.m_rvalid = 1'b0; bus.m_rresp = 2'b00; bus.m_rdata = 32'h0;
      aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; aw_prev = 1'b0;
      aw_a = 4'h0; ar_a = 4'h0; w_d = 32'h0;
      w_stall_left = 0; r_delay_left = 0;
      for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    end else begin
      if (c_aw) begin aw_got = 1'b1; aw_a = c_awaddr; end
      if (c_w)  begin w_got = 1'b1; w_d = c_wdata; end
      if (c_b)  bus.m_bvalid = 1'b0;
      if (c_r)  bus.m_rvalid = 1'b0;
      if (c_ar) begin ar_got = 1'b1; ar_a = c_araddr; r_delay_left = r_delay_cfg; end
      if (aw_got && w_got) begin
        mem[aw_a[3:2]] = w_d;
        bus.m_bvalid = 1'b1;
        bus.m_bresp  = bresp_cfg;
        aw_got = 1'b0;
        w_got  = 1'b0;
      end
      if (ar_got) begin
        if (r_delay_left > 0) begin
          r_delay_left--;
        end else begin
          bus.m_rvalid = 1'b1;
          bus.m_rdata  = mem[ar_a[3:2]];
          bus.m_rresp  = rresp_cfg;
          ar_got = 1'b0;
        end
      end
      bus.m_awready = 1'b1;
      bus.m_arready = 1'b1;
      if (bus.m_awvalid && !aw_prev) w_stall_left = w_stall_cfg;
      aw_prev = bus.m_awvalid;
      if (bus.m_wvalid && w_stall_left > 0) begin
        bus.m_wready = 1'b0;
        w_stall_left--;
      end else begin
        bus.m_wready = 1'b1;
      end
    end
  end

  // Post one command from requester idx and wait (bounded) for its done pulse
  task automatic run_one(input int idx, input logic w, input logic [3:0] a, input logic [31:0] d,
                         output logic [1:0] o_done, output logic [31:0] o_rdata,
                         output logic [1:0] o_resp, output logic o_busy, output int o_cyc);
    o_done = 2'b00; o_rdata = 32'h0; o_resp = 2'b00; o_busy = 1'b0; o_cyc = 0;
    if (idx == 0) begin we[0] = w; addr0 = a; wdata0 = d; req[0] = 1'b1; end
    else          begin we[1] = w; addr1 = a; wdata1 = d; req[1] = 1'b1; end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        o_done = done; o_rdata = rdata; o_resp = resp; o_busy = busy; o_cyc = k;
        break;
      end
    end
    req[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({done, busy, rdata, resp} !== 37'h0) begin
      failures++;
      $display("FAIL reset_outputs: done=%b busy=%b rdata=%h resp=%b, want all zero", done, busy, rdata, resp);
    end
    checks++;
    if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.m_arvalid, bus.m_rready} !== 5'b0) begin
      failures++;
      $display("FAIL reset_axi_handshake: aw/w/b/ar/r=%b%b%b%b%b, want 00000",
               bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.m_arvalid, bus.m_rready);
    end
    checks++;
    if ({bus.m_awaddr, bus.m_araddr, bus.m_wdata} !== 40'h0 || bus.m_wstrb !== 4'hF) begin
      failures++;
      $display("FAIL reset_axi_payload: awaddr=%h araddr=%h wdata=%h wstrb=%h, want 0 0 0 F",
               bus.m_awaddr, bus.m_araddr, bus.m_wdata, bus.m_wstrb);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_rw();
    logic [1:0] d; logic [31:0] rd; logic [1:0] rs; logic bz; int cyc;
    for (int i = 0; i < 4; i++) begin
      run_one(0, 1'b1, 4'(i * 4), 32'(i + 1), d, rd, rs, bz, cyc);
      checks++;
      if (d !== 2'b01 || cyc != 3 || rs !== 2'b00 || rd !== 32'h0 || bz !== 1'b1) begin
        failures++;
        $display("FAIL single_write[%0d]: done=%b cyc=%0d resp=%b rdata=%h busy=%b, want 01 3 00 0 1", i, d, cyc, rs, rd, bz);
      end
      @(negedge clk);
      checks++;
      if (done !== 2'b00 || busy !== 1'b0) begin
        failures++;
        $display("FAIL single_write_pulse[%0d]: done=%b busy=%b, want 00 0", i, done, busy);
      end
    end
    for (int i = 0; i < 4; i++) begin
      run_one(0, 1'b0, 4'(i * 4), 32'h0, d, rd, rs, bz, cyc);
      checks++;
      if (d !== 2'b01 || cyc != 3 || rs !== 2'b00 || rd !== 32'(i + 1)) begin
        failures++;
        $display("FAIL single_read[%0d]: done=%b cyc=%0d resp=%b rdata=%h, want 01 3 00 %h", i, d, cyc, rs, rd, 32'(i + 1));
      end
      @(negedge clk);
      checks++;
      if (done !== 2'b00) begin
        failures++;
        $display("FAIL single_read_pulse[%0d]: done=%b, want 00", i, done);
      end
    end
  endtask

  task automatic test_slverr_read();
    logic [1:0] d; logic [31:0] rd; logic [1:0] rs; logic bz; int cyc; int extra_ar;
    rresp_cfg = 2'b10;
    run_one(0, 1'b0, 4'h8, 32'h0, d, rd, rs, bz, cyc);
    rresp_cfg = 2'b00;
    checks++;
    if (d !== 2'b01 || rs !== 2'b10 || rd !== 32'h3) begin
      failures++;
      $display("FAIL slverr_read: done=%b resp=%b rdata=%h, want 01 10 00000003", d, rs, rd);
    end
    extra_ar = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.m_arvalid) extra_ar++;
    end
    checks++;
    if (extra_ar != 0) begin
      failures++;
      $display("FAIL slverr_no_retry: arvalid cycles after done=%0d, want 0", extra_ar);
    end
  endtask

  task automatic test_misaligned_read();
    logic [1:0] d; logic [31:0] rd; logic [1:0] rs; int cyc; logic got_ar; logic [3:0] seen;
    d = 2'b00; rd = 32'h0; rs = 2'b00; cyc = 0; got_ar = 1'b0; seen = 4'hF;
    we[1] = 1'b0; addr1 = 4'h7; req[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.m_arvalid) begin got_ar = 1'b1; seen = bus.m_araddr; end
      if (done != 2'b00) begin d = done; rd = rdata; rs = resp; cyc = k; break; end
    end
    req[1] = 1'b0;
    checks++;
    if (!got_ar || seen !== 4'h4) begin
      failures++;
      $display("FAIL misaligned_araddr: seen=%0d araddr=%h, want 1 4", got_ar, seen);
    end
    checks++;
    if (d !== 2'b10 || rd !== 32'h2 || rs !== 2'b00 || cyc != 3) begin
      failures++;
      $display("FAIL misaligned_read: done=%b rdata=%h resp=%b cyc=%0d, want 10 00000002 00 3", d, rd, rs, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_wstall();
    logic [1:0] d; logic [31:0] rd; logic [1:0] rs; logic bz; int cyc;
    int aw_cnt, w_cnt, bad_data, bready_early, first_bready;
    d = 2'b00; rs = 2'b00; cyc = 0;
    aw_cnt = 0; w_cnt = 0; bad_data = 0; bready_early = 0; first_bready = 0;
    w_stall_cfg = 3;
    we[0] = 1'b1; addr0 = 4'hC; wdata0 = 32'h77; req[0] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.m_awvalid) aw_cnt++;
      if (bus.m_wvalid) begin
        w_cnt++;
        if (bus.m_wdata !== 32'h77) bad_data++;
      end
      if (bus.m_bready && bus.m_wvalid) bready_early++;
      if (bus.m_bready && first_bready == 0) first_bready = k;
      if (done != 2'b00) begin d = done; rs = resp; cyc = k; break; end
    end
    req[0] = 1'b0;
    w_stall_cfg = 0;
    checks++;
    if (aw_cnt != 1 || w_cnt != 4) begin
      failures++;
      $display("FAIL wstall_valids: awvalid cycles=%0d wvalid cycles=%0d, want 1 4", aw_cnt, w_cnt);
    end
    checks++;
    if (bad_data != 0 || bready_early != 0 || first_bready != 5) begin
      failures++;
      $display("FAIL wstall_order: bad_wdata=%0d bready_with_w=%0d first_bready=%0d, want 0 0 5", bad_data, bready_early, first_bready);
    end
    checks++;
    if (d !== 2'b01 || rs !== 2'b00 || cyc != 6) begin
      failures++;
      $display("FAIL wstall_done: done=%b resp=%b cyc=%0d, want 01 00 6", d, rs, cyc);
    end
    @(negedge clk);
    run_one(0, 1'b0, 4'hC, 32'h0, d, rd, rs, bz, cyc);
    checks++;
    if (d !== 2'b01 || rd !== 32'h77) begin
      failures++;
      $display("FAIL wstall_readback: done=%b rdata=%h, want 01 00000077", d, rd);
    end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic [1:0] seq [4]; logic [31:0] dat [4]; int t [4]; int n;
    logic [1:0] want_seq [4]; logic [31:0] want_dat [4];
    want_seq[0] = 2'b01; want_seq[1] = 2'b10; want_seq[2] = 2'b01; want_seq[3] = 2'b10;
    want_dat[0] = 32'hA5; want_dat[1] = 32'h5A; want_dat[2] = 32'hA5; want_dat[3] = 32'h5A;
    for (int i = 0; i < 4; i++) begin seq[i] = 2'b00; dat[i] = 32'h0; t[i] = 0; end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    // Simultaneous writes straight after reset
    we = 2'b11; addr0 = 4'h0; wdata0 = 32'hA5; addr1 = 4'h4; wdata1 = 32'h5A; req = 2'b11;
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        seq[n] = done; n++;
        req = req & ~done;
        if (n == 2) break;
      end
    end
    req = 2'b00;
    checks++;
    if (n != 2 || seq[0] !== 2'b01 || seq[1] !== 2'b10) begin
      failures++;
      $display("FAIL arb_first_pair: count=%0d order=%b,%b, want 2 01,10", n, seq[0], seq[1]);
    end
    @(negedge clk);
    // Both held continuously: grants alternate; done-to-done distance 4 edges (5 cycles inclusive)
    we = 2'b00; addr0 = 4'h0; addr1 = 4'h4; req = 2'b11;
    n = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        seq[n] = done; dat[n] = rdata; t[n] = k; n++;
        if (n == 4) begin req = 2'b00; break; end
      end
    end
    req = 2'b00;
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL arb_alternate_count: dones=%0d, want 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seq[i] !== want_seq[i] || dat[i] !== want_dat[i]) begin
        failures++;
        $display("FAIL arb_alternate[%0d]: done=%b rdata=%h, want %b %h", i, seq[i], dat[i], want_seq[i], want_dat[i]);
      end
    end
    checks++;
    if (t[0] != 3 || t[1] - t[0] != 4 || t[2] - t[1] != 4 || t[3] - t[2] != 4) begin
      failures++;
      $display("FAIL arb_spacing: done edges=%0d,%0d,%0d,%0d, want 3,7,11,15", t[0], t[1], t[2], t[3]);
    end
    @(negedge clk);
  endtask

  task automatic test_areset_mid_read();
    logic got; logic saw_done; logic [1:0] first; int n;
    got = 1'b0; saw_done = 1'b0; first = 2'b00; n = 0;
    // Requester 0 is served last, so only a pointer reset lets it win again below
    r_delay_cfg = 20;
    we[0] = 1'b0; addr0 = 4'h8; req[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.m_rready) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL areset_reach_rresp: rready seen=%0d, want 1", got);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.m_arvalid, bus.m_rready, busy, done} !== 8'h00) begin
      failures++;
      $display("FAIL areset_immediate: aw/w/b/ar/r=%b%b%b%b%b busy=%b done=%b, want 00000 0 00",
               bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.m_arvalid, bus.m_rready, busy, done);
    end
    req = 2'b00;
    r_delay_cfg = 0;
    repeat (3) begin
      @(negedge clk);
      if (done != 2'b00) saw_done = 1'b1;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done != 2'b00) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL areset_no_done: done pulse seen=%0d, want 0", saw_done);
    end
    we = 2'b00; addr0 = 4'h0; addr1 = 4'h4; req = 2'b11;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done != 2'b00) begin first = done; n = k; break; end
    end
    req = 2'b00;
    checks++;
    if (first !== 2'b01 || n != 3) begin
      failures++;
      $display("FAIL areset_r0_first: done=%b cyc=%0d, want 01 3", first, n);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = 32'h0; wdata1 = 32'h0;
    w_stall_cfg = 0; r_delay_cfg = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
    test_reset();
    test_single_rw();
    test_slverr_read();
    test_misaligned_read();
    test_wstall();
    test_arbitration();
    test_areset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
